// File: rtl/execute_pkg.sv
// Shared types and bus widths for the memory responder and its initiators.
`ifndef PLEN
`define PLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package execute;

    // Kind of memory access carried with a request.
    typedef enum logic [1:0] {
        MEM_READ       = 2'd0,
        MEM_WRITE_BYTE = 2'd1,
        MEM_WRITE_HALF = 2'd2,
        MEM_WRITE_WORD = 2'd3
    } memory_access_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a memory initiator and mem_responder.
`ifndef PLEN
`define PLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

// Handshake: the initiator raises mem_cycle with paddr/access/data stable and
// holds it until it sees mem_ack, a single-cycle pulse from the responder.
// The responder samples the request once at acceptance. If mem_cycle is
// still high at the edge that ends the ack cycle, that is taken as the next
// request, so the initiator must either drop mem_cycle or present the new
// request while mem_ack is high.
interface mem_responder_if;
    logic                        mem_cycle;
    logic [`PLEN-1:0]            mem_paddr;
    execute::memory_access_t     mem_access;
    logic [`XLEN-1:0]            mem_data_out;
    logic [3:0][`XLEN-1:0]       mem_data_in;
    logic                        mem_ack;
    logic                        oob_flag;

    modport master (
        output mem_cycle, mem_paddr, mem_access, mem_data_out,
        input  mem_data_in, mem_ack, oob_flag
    );

    modport slave (
        input  mem_cycle, mem_paddr, mem_access, mem_data_out,
        output mem_data_in, mem_ack, oob_flag
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: word-organised backing store, four-word
// wrapped read groups, lane-masked writes and a sticky out-of-range flag.
`ifndef PLEN
`define PLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output logic [1:0]       o_dbg_state
);
    import execute::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [`PLEN-1:0]     r_paddr;
    memory_access_t       r_access;
    logic [31:0]          r_wdata;
    logic                 r_ack;
    logic [3:0][31:0]     r_rdata;
    logic                 r_oob;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [AW-1:0]        w_word;
    logic                 w_oob;
    logic                 w_done;
    logic                 w_commit;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [AW-1:0]        w_idx [4];

    assign w_word   = r_paddr[AW+1:2];
    // Store size is a power of two, so any set bit above the index is out of range.
    assign w_oob    = |r_paddr[`PLEN-1:AW+2];
    assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit = w_done && !reset && !w_oob && (r_access != MEM_READ);

    // Lane enables and lane-replicated write data for the captured request.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_wdata;
        case (r_access)
            MEM_WRITE_BYTE: begin
                w_be[r_paddr[1:0]] = 1'b1;
                w_wdata            = {4{r_wdata[7:0]}};
            end
            MEM_WRITE_HALF: begin
                w_be    = r_paddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            MEM_WRITE_WORD: w_be = 4'b1111;
            default:        w_be = 4'b0000;
        endcase
    end

    // Read group indices: addressed word first, wrapping inside its 4-word block.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i] = (w_word & ~AW'(3)) | AW'(2'(w_word[1:0] + 2'(i)));
        end
    end

    // Request FSM with registered ack, read data and out-of-range flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_oob   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                // ACK accepts like IDLE so back-to-back requests keep LATENCY+1 spacing.
                S_IDLE, S_ACK: begin
                    if (bus.mem_cycle) begin
                        r_paddr  <= bus.mem_paddr;
                        r_access <= bus.mem_access;
                        r_wdata  <= bus.mem_data_out;
                        r_cnt    <= 4'(LATENCY - 1);
                        r_state  <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        if (w_oob) begin
                            r_oob <= 1'b1;
                        end
                        if (r_access == MEM_READ) begin
                            for (int i = 0; i < 4; i++) begin
                                r_rdata[i] <= w_oob ? 32'h0 : r_mem[w_idx[i]];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Backing store write; not reset so contents survive a reset.
    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign bus.mem_ack     = r_ack;
    assign bus.mem_data_in = r_rdata;
    assign bus.oob_flag    = r_oob;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_WORDS=4096, LATENCY=2).
module tb_mem_responder;
    import execute::*;

    localparam logic [31:0] WA = 32'hA0A0_0001;
    localparam logic [31:0] WB = 32'hB0B0_0002;
    localparam logic [31:0] WC = 32'hC0C0_0003;
    localparam logic [31:0] WD = 32'hD0D0_0004;
    localparam logic [31:0] W0 = 32'h0123_4567;
    localparam logic [31:0] W1 = 32'h89AB_CDEF;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_pass;

    mem_responder_if bus();

    mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Waits for mem_ack, returning the number of edges observed.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            cyc++;
            if (bus.mem_ack) return;
        end
        chk("ack_timeout", 1'b0, 1'b1);
    endtask

    // One complete request: fixed latency, inputs scrambled after acceptance,
    // single-cycle ack.
    task automatic do_req(input string tag, input memory_access_t acc,
                          input logic [31:0] addr, input logic [31:0] data);
        int c;
        bus.mem_cycle    = 1'b1;
        bus.mem_paddr    = addr;
        bus.mem_access   = acc;
        bus.mem_data_out = data;
        @(posedge clock); #1;
        chk({tag, "_early"}, bus.mem_ack, 1'b0);
        bus.mem_paddr    = addr ^ 32'h0000_4000;
        bus.mem_access   = (acc == MEM_READ) ? MEM_WRITE_WORD : MEM_READ;
        bus.mem_data_out = 32'hCAFE_0000;
        wait_ack(c);
        chk({tag, "_lat"}, c + 1, 3);
        bus.mem_cycle = 1'b0;
        @(posedge clock); #1;
        chk({tag, "_pulse"}, bus.mem_ack, 1'b0);
    endtask

    initial begin
        int   c;
        logic ack_seen;
        n_checks         = 0;
        n_pass           = 0;
        reset            = 1'b1;
        bus.mem_cycle    = 1'b0;
        bus.mem_paddr    = '0;
        bus.mem_access   = MEM_READ;
        bus.mem_data_out = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ack", bus.mem_ack, 1'b0);
        chk("rst_data", bus.mem_data_in, 128'h0);
        chk("rst_oob", bus.oob_flag, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Word write then read back
        do_req("wr10", MEM_WRITE_WORD, 32'h10, 32'hDEAD_BEEF);
        chk("wr10_hold", bus.mem_data_in, 128'h0);
        do_req("rd10", MEM_READ, 32'h10, 32'h0);
        chk("rd10_data", bus.mem_data_in[0], 32'hDEAD_BEEF);

        // Wrapped read groups
        do_req("pa", MEM_WRITE_WORD, 32'h100, WA);
        do_req("pb", MEM_WRITE_WORD, 32'h104, WB);
        do_req("pc", MEM_WRITE_WORD, 32'h108, WC);
        do_req("pd", MEM_WRITE_WORD, 32'h10C, WD);
        do_req("rd108", MEM_READ, 32'h108, 32'h0);
        chk("rd108_grp", bus.mem_data_in, {WB, WA, WD, WC});
        do_req("rd10b", MEM_READ, 32'h10B, 32'h0);
        chk("rd10b_grp", bus.mem_data_in, {WB, WA, WD, WC});
        do_req("rd100", MEM_READ, 32'h100, 32'h0);
        chk("rd100_grp", bus.mem_data_in, {WD, WC, WB, WA});
        do_req("rd104", MEM_READ, 32'h104, 32'h0);
        chk("rd104_grp", bus.mem_data_in, {WA, WD, WC, WB});

        // Byte and half lane writes (lane k = bits [8k+7:8k])
        do_req("w20", MEM_WRITE_WORD, 32'h20, 32'h1122_3344);
        do_req("wb22", MEM_WRITE_BYTE, 32'h22, 32'h1234_56AA);
        do_req("rd20a", MEM_READ, 32'h20, 32'h0);
        chk("rd20a_data", bus.mem_data_in[0], 32'h11AA_3344);
        do_req("wh21", MEM_WRITE_HALF, 32'h21, 32'hFFFF_5566);
        do_req("rd20b", MEM_READ, 32'h20, 32'h0);
        chk("rd20b_data", bus.mem_data_in[0], 32'h11AA_5566);
        do_req("wh22", MEM_WRITE_HALF, 32'h22, 32'h0000_7788);
        do_req("wb23", MEM_WRITE_BYTE, 32'h23, 32'h0000_0099);
        do_req("rd20c", MEM_READ, 32'h20, 32'h0);
        chk("rd20c_data", bus.mem_data_in[0], 32'h9988_5566);

        // Back-to-back reads with mem_cycle held across the ack
        do_req("w0", MEM_WRITE_WORD, 32'h0, W0);
        do_req("w4", MEM_WRITE_WORD, 32'h4, W1);
        bus.mem_cycle  = 1'b1;
        bus.mem_paddr  = 32'h0;
        bus.mem_access = MEM_READ;
        wait_ack(c);
        chk("b2b_first_lat", c, 3);
        chk("b2b_first_data", bus.mem_data_in[0], W0);
        bus.mem_paddr = 32'h4;
        wait_ack(c);
        chk("b2b_spacing", c, 3);
        chk("b2b_second_data", bus.mem_data_in[0], W1);
        bus.mem_cycle = 1'b0;
        @(posedge clock); #1;
        chk("b2b_pulse", bus.mem_ack, 1'b0);
        @(posedge clock); #1;
        chk("b2b_idle", dbg_state, 2'd0);

        // Out-of-range write and read
        chk("oob_before", bus.oob_flag, 1'b0);
        do_req("woob", MEM_WRITE_WORD, 32'h4000, 32'h1234_5678);
        chk("oob_set", bus.oob_flag, 1'b1);
        do_req("rd0", MEM_READ, 32'h0, 32'h0);
        chk("oob_store", bus.mem_data_in[0], W0);
        do_req("roob", MEM_READ, 32'h4000, 32'h0);
        chk("oob_rdata", bus.mem_data_in, 128'h0);
        chk("oob_sticky", bus.oob_flag, 1'b1);

        // Reset during WAIT aborts the write
        do_req("w30", MEM_WRITE_WORD, 32'h30, 32'h0BAD_F00D);
        bus.mem_cycle    = 1'b1;
        bus.mem_paddr    = 32'h30;
        bus.mem_access   = MEM_WRITE_WORD;
        bus.mem_data_out = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        chk("abort_in_wait", dbg_state, 2'd1);
        reset         = 1'b1;
        bus.mem_cycle = 1'b0;
        @(posedge clock); #1;
        reset    = 1'b0;
        ack_seen = bus.mem_ack;
        repeat (4) begin
            @(posedge clock); #1;
            ack_seen = ack_seen | bus.mem_ack;
        end
        chk("abort_no_ack", ack_seen, 1'b0);
        chk("abort_state", dbg_state, 2'd0);
        chk("abort_oob_clr", bus.oob_flag, 1'b0);
        chk("abort_data_clr", bus.mem_data_in, 128'h0);
        do_req("rd30", MEM_READ, 32'h30, 32'h0);
        chk("rd30_data", bus.mem_data_in[0], 32'h0BAD_F00D);

        // Request held across reset deassertion
        reset          = 1'b1;
        bus.mem_cycle  = 1'b1;
        bus.mem_paddr  = 32'h10;
        bus.mem_access = MEM_READ;
        @(posedge clock); #1;
        reset = 1'b0;
        wait_ack(c);
        chk("post_rst_lat", c, 3);
        chk("post_rst_data", bus.mem_data_in[0], 32'hDEAD_BEEF);
        bus.mem_cycle = 1'b0;
        @(posedge clock); #1;

        // Write leaves read data untouched
        do_req("w14", MEM_WRITE_WORD, 32'h14, 32'h5555_AAAA);
        chk("w14_hold", bus.mem_data_in[0], 32'hDEAD_BEEF);
        do_req("rd14", MEM_READ, 32'h14, 32'h0);
        chk("rd14_data", bus.mem_data_in[0], 32'h5555_AAAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
